// File: rtl/ula_nbits_serial.sv
// Serial 74181-style ALU: evaluates one 4-bit slice per clock, LSB slice first,
// with a registered ripple carry and valid/ready handshakes on both sides.
module ula_nbits_serial #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             c_out,
   output logic             a_eq_b
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [3:0]        r_s;
   logic              r_m;
   logic              r_carry;      // active-high internal carry into the current slice
   logic [KW-1:0]     r_k;
   logic [WIDTH-5:0]  r_f_sh;       // upper result bits gathered so far, LSB-aligned at entry to DONE
   logic              r_in_ready;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_f;
   logic              r_c_out;
   logic              r_a_eq_b;

   logic [4:0]        w_slice;
   logic [WIDTH-1:0]  w_f_full;

   // One 74181 slice on active-high data; returns {carry_out, f[3:0]}.
   function automatic logic [4:0] alu181_slice(input logic [3:0] a4,
                                               input logic [3:0] b4,
                                               input logic [3:0] sel,
                                               input logic       mode,
                                               input logic       cin);
      logic       c;
      logic       t1;
      logic       t2;
      logic [3:0] fo;
      c  = cin;
      fo = '0;
      for (int i = 0; i < 4; i++) begin
         t1    = ~(a4[i] | (b4[i] & sel[0]) | (~b4[i] & sel[1]));
         t2    = ~((a4[i] & ~b4[i] & sel[2]) | (a4[i] & b4[i] & sel[3]));
         fo[i] = t1 ^ t2 ^ (mode | c);
         c     = ~t2 | (~t1 & c);
      end
      return {c, fo};
   endfunction

   assign w_slice  = alu181_slice(r_a[3:0], r_b[3:0], r_s, r_m, r_carry);
   assign w_f_full = {w_slice[3:0], r_f_sh};

   // Control FSM with operand shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_m         <= 1'b0;
         r_carry     <= 1'b0;
         r_k         <= '0;
         r_f_sh      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_f         <= '0;
         r_c_out     <= 1'b1;
         r_a_eq_b    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_s        <= s;
                  r_m        <= m;
                  r_carry    <= ~c_in;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 4;
               r_b     <= r_b >> 4;
               r_f_sh  <= w_f_full[WIDTH-1:4];
               r_carry <= w_slice[4];
               r_k     <= r_k + KW'(1);
               if (r_k == KW'(N - 1)) begin
                  r_f         <= w_f_full;
                  r_c_out     <= ~w_slice[4];
                  r_a_eq_b    <= &w_f_full;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign f         = r_f;
   assign c_out     = r_c_out;
   assign a_eq_b    = r_a_eq_b;

endmodule
